// File: rtl/idac_segment_decoder_pkg.sv
// Shared constants, power-state encoding and select payload for the IDAC segment decoder.
package idac_segment_decoder_pkg;

  localparam int unsigned IDAC_NTHERM     = 17;
  localparam int unsigned IDAC_NBIN       = 6;
  localparam int unsigned IDAC_CODE_W     = 11;
  localparam int unsigned IDAC_CODE_MAX   = IDAC_NTHERM * (2 ** IDAC_NBIN) + (2 ** IDAC_NBIN) - 1;
  localparam int unsigned IDAC_WARMUP_CYC = 16;
  localparam int unsigned IDAC_N_W        = IDAC_CODE_W - IDAC_NBIN;
  localparam int unsigned IDAC_PTR_W      = $clog2(IDAC_NTHERM);
  localparam int unsigned IDAC_WCNT_W     = $clog2(IDAC_WARMUP_CYC);

  typedef enum logic [1:0] {IDAC_OFF, IDAC_WARMUP, IDAC_RUN} idac_pwr_state_e;

  // One decoded sample as it travels through the decode and output registers
  typedef struct packed {
    logic [IDAC_NTHERM-1:0] therm;
    logic [IDAC_NBIN-1:0]   bin;
    logic                   red;
    logic                   sat;
  } idac_sel_t;

endpackage

// File: rtl/idac_segment_decoder_if.sv
// Code input handshake plus decoded select outputs of the IDAC segment decoder.
//   master: code source / select consumer; slave: the decoder.
interface idac_segment_decoder_if;
  import idac_segment_decoder_pkg::*;

  logic [IDAC_CODE_W-1:0] code_in;
  logic                   code_vld;
  logic                   code_rdy;
  logic [IDAC_NTHERM-1:0] therm_sel;
  logic [IDAC_NBIN-1:0]   bin_sel;
  logic                   bin0_red_sel;
  logic                   sat_flag;

  modport master (
    output code_in, code_vld,
    input  code_rdy, therm_sel, bin_sel, bin0_red_sel, sat_flag
  );

  modport slave (
    input  code_in, code_vld,
    output code_rdy, therm_sel, bin_sel, bin0_red_sel, sat_flag
  );
endinterface

// File: rtl/idac_segment_decoder_dwa_rotator.sv
// DWA pointer and rotated thermometric mask.
//   clkin, rstb : clock, async active-low reset
//   n           : number of segments to turn on (0..NTHERM)
//   advance     : move pointer by n this edge
//   dwa_ena     : 1 = rotate mask by pointer, 0 = fixed order
//   clear       : synchronous pointer clear (wins over advance)
//   mask_c      : combinational mask from current pointer and n
module idac_segment_decoder_dwa_rotator
  import idac_segment_decoder_pkg::*;
(
  input  logic                   clkin,
  input  logic                   rstb,
  input  logic [IDAC_N_W-1:0]    n,
  input  logic                   advance,
  input  logic                   dwa_ena,
  input  logic                   clear,
  output logic [IDAC_NTHERM-1:0] mask_c
);

  localparam int unsigned SUM_W = IDAC_PTR_W + 1;

  logic [IDAC_PTR_W-1:0]  ptr_q;
  logic [IDAC_PTR_W-1:0]  ptr_d;
  logic [SUM_W-1:0]       sum_c;
  logic [IDAC_NTHERM-1:0] base_c;
  logic [IDAC_PTR_W-1:0]  idx_c;

  // Pointer advance modulo NTHERM; n = NTHERM lands back on the same pointer
  always_comb begin
    sum_c = SUM_W'(ptr_q) + SUM_W'(n);
    if (sum_c >= SUM_W'(IDAC_NTHERM)) sum_c = sum_c - SUM_W'(IDAC_NTHERM);
    ptr_d = IDAC_PTR_W'(sum_c);
  end

  // Unrotated thermometer, then rotate left by ptr when DWA is on
  always_comb begin
    base_c = '0;
    mask_c = '0;
    idx_c  = '0;
    for (int unsigned i = 0; i < IDAC_NTHERM; i++) begin
      base_c[IDAC_PTR_W'(i)] = (IDAC_N_W'(i) < n);
    end
    for (int unsigned i = 0; i < IDAC_NTHERM; i++) begin
      if (i >= 32'(ptr_q)) idx_c = IDAC_PTR_W'(i - 32'(ptr_q));
      else                 idx_c = IDAC_PTR_W'(i + IDAC_NTHERM - 32'(ptr_q));
      mask_c[IDAC_PTR_W'(i)] = dwa_ena ? base_c[idx_c] : base_c[IDAC_PTR_W'(i)];
    end
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb)        ptr_q <= '0;
    else if (clear)   ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/idac_segment_decoder.sv
// IDAC segment decoder: power sequencing, code saturation, thermometric/binary decode
// with optional DWA rotation.
//   clkin, rstb : clock, async active-low reset
//   pdb         : power-down negate (0 = off)
//   dwa_ena     : DWA rotation enable
//   dac_on      : high while in RUN
//   bus         : code handshake in, registered selects out
module idac_segment_decoder
  import idac_segment_decoder_pkg::*;
(
  input  logic                  clkin,
  input  logic                  rstb,
  input  logic                  pdb,
  input  logic                  dwa_ena,
  output logic                  dac_on,
  idac_segment_decoder_if.slave bus
);

  idac_pwr_state_e        state_q, state_d;
  logic [IDAC_WCNT_W-1:0] cnt_q, cnt_d;

  logic                   run_c;
  logic                   accept_c;
  logic [IDAC_CODE_W-1:0] s1_code;
  logic                   s1_sat;
  logic                   s1_dwa;
  logic                   s1_new;
  logic [IDAC_NTHERM-1:0] mask_c;
  idac_sel_t              s2_q;
  idac_sel_t              out_q;

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDAC_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and handshake; pdb low always forces OFF
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus.code_rdy = 1'b0;
    dac_on       = 1'b0;
    case (state_q)
      IDAC_OFF: begin
        cnt_d = '0;
        if (pdb) state_d = IDAC_WARMUP;
      end
      IDAC_WARMUP: begin
        if (cnt_q == IDAC_WCNT_W'(IDAC_WARMUP_CYC - 1)) begin
          state_d = IDAC_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDAC_RUN: begin
        bus.code_rdy = 1'b1;
        dac_on       = 1'b1;
      end
      default: state_d = IDAC_OFF;
    endcase
    if (!pdb) begin
      state_d = IDAC_OFF;
      cnt_d   = '0;
    end
  end

  // A falling pdb on the accept edge discards the sample via run_c
  assign run_c    = (state_q == IDAC_RUN) && pdb;
  assign accept_c = run_c && bus.code_vld;

  // Stage 1: clamp and hold; s1_new marks a freshly accepted sample
  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      s1_code <= '0;
      s1_sat  <= 1'b0;
      s1_dwa  <= 1'b0;
      s1_new  <= 1'b0;
    end else if (!run_c) begin
      s1_code <= '0;
      s1_sat  <= 1'b0;
      s1_dwa  <= 1'b0;
      s1_new  <= 1'b0;
    end else if (accept_c) begin
      s1_sat  <= (bus.code_in > IDAC_CODE_W'(IDAC_CODE_MAX));
      s1_code <= (bus.code_in > IDAC_CODE_W'(IDAC_CODE_MAX)) ?
                 IDAC_CODE_W'(IDAC_CODE_MAX) : bus.code_in;
      s1_dwa  <= dwa_ena;
      s1_new  <= 1'b1;
    end else begin
      s1_new  <= 1'b0;
    end
  end

  idac_segment_decoder_dwa_rotator u_rot (
    .clkin   (clkin),
    .rstb    (rstb),
    .n       (s1_code[IDAC_CODE_W-1:IDAC_NBIN]),
    .advance (s1_new && s1_dwa),
    .dwa_ena (s1_dwa),
    .clear   (!run_c || !dwa_ena),
    .mask_c  (mask_c)
  );

  // Stage 2 decodes only new samples so held codes keep a stable rotation
  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      s2_q  <= '0;
      out_q <= '0;
    end else if (!run_c) begin
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      if (s1_new) begin
        s2_q.therm <= mask_c;
        s2_q.bin   <= s1_code[IDAC_NBIN-1:0];
        s2_q.red   <= s1_code[0];
        s2_q.sat   <= s1_sat;
      end
      out_q <= s2_q;
    end
  end

  assign bus.therm_sel    = out_q.therm;
  assign bus.bin_sel      = out_q.bin;
  assign bus.bin0_red_sel = out_q.red;
  assign bus.sat_flag     = out_q.sat;

endmodule

// File: tb/tb_idac_segment_decoder.sv
// Directed bench for idac_segment_decoder.
module tb_idac_segment_decoder;
  import idac_segment_decoder_pkg::*;

  logic clkin = 1'b0;
  logic rstb;
  logic pdb;
  logic dwa_ena;
  logic dac_on;
  int   checks   = 0;
  int   failures = 0;

  idac_segment_decoder_if bus ();

  idac_segment_decoder dut (
    .clkin   (clkin),
    .rstb    (rstb),
    .pdb     (pdb),
    .dwa_ena (dwa_ena),
    .dac_on  (dac_on),
    .bus     (bus)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Accept one code, then let it travel to the outputs (2 edges after accept)
  task automatic send(input logic [10:0] c);
    bus.code_in  = c;
    bus.code_vld = 1'b1;
    tick();
    bus.code_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input logic [16:0] th, input logic [5:0] bn,
                           input logic red, input logic sat);
    check({tag, "_therm"}, 32'(bus.therm_sel), 32'(th));
    check({tag, "_bin"},   32'(bus.bin_sel),   32'(bn));
    check({tag, "_red"},   32'(bus.bin0_red_sel), 32'(red));
    check({tag, "_sat"},   32'(bus.sat_flag),  32'(sat));
  endtask

  // Bounded wait for code_rdy; reports how many edges it took
  task automatic wait_run(output int n_edges, output logic [16:0] therm_or);
    n_edges  = 0;
    therm_or = '0;
    while (bus.code_rdy !== 1'b1 && n_edges < 60) begin
      tick();
      n_edges++;
      therm_or |= bus.therm_sel;
    end
    if (bus.code_rdy !== 1'b1) check("run_timeout", 32'(bus.code_rdy), 32'd1);
  endtask

  int          n_edges;
  logic [16:0] therm_or;
  logic [16:0] held;

  initial begin
    rstb         = 1'b0;
    pdb          = 1'b0;
    dwa_ena      = 1'b0;
    bus.code_in  = '0;
    bus.code_vld = 1'b0;
    tick();
    tick();
    check_out("reset", 17'h0, 6'h0, 1'b0, 1'b0);
    check("reset_rdy", 32'(bus.code_rdy), 32'd0);
    check("reset_dac_on", 32'(dac_on), 32'd0);

    // Power-up: one OFF edge then WARMUP_CYC edges of warm-up
    pdb  = 1'b1;
    rstb = 1'b1;
    wait_run(n_edges, therm_or);
    check("warmup_len", 32'(n_edges), 32'(1 + IDAC_WARMUP_CYC));
    check("warmup_sel", 32'(therm_or), 32'd0);
    check("run_dac_on", 32'(dac_on), 32'd1);

    // Latency and plain decode: 677 = 10*64 + 37
    bus.code_in  = 11'd677;
    bus.code_vld = 1'b1;
    tick();
    bus.code_vld = 1'b0;
    tick();
    check("lat_early", 32'(bus.therm_sel), 32'd0);
    tick();
    check_out("dec677", 17'h003FF, 6'h25, 1'b1, 1'b0);

    // Saturation, then back in range
    send(11'd2047);
    check_out("sat", 17'h1FFFF, 6'h3F, 1'b1, 1'b1);
    send(11'd5);
    check_out("unsat", 17'h0, 6'h05, 1'b1, 1'b0);

    // DWA from pointer 0: n=10, n=10 (wraps, ptr=3), n=1 shows ptr=3
    dwa_ena = 1'b1;
    send(11'd640);
    check("dwa1", 32'(bus.therm_sel), 32'h003FF);
    send(11'd640);
    check("dwa2", 32'(bus.therm_sel), 32'h1FC07);
    send(11'd64);
    check("dwa_ptr3", 32'(bus.therm_sel), 32'h00008);
    // n=17 lights everything and leaves ptr at 4
    send(11'd1100);
    check("dwa_full", 32'(bus.therm_sel), 32'h1FFFF);
    send(11'd64);
    check("dwa_ptr4", 32'(bus.therm_sel), 32'h00010);

    // Hold: ptr 5, n=10 -> bits 5..14; outputs stay put with no accepts
    send(11'd677);
    check("hold_first", 32'(bus.therm_sel), 32'h07FE0);
    held = bus.therm_sel;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("hold", 32'(bus.therm_sel), 32'(held));
    end
    send(11'd64);
    check("hold_ptr15", 32'(bus.therm_sel), 32'h08000);

    // Power-down mid-stream with a sample on the bus
    bus.code_in  = 11'd2047;
    bus.code_vld = 1'b1;
    tick();
    tick();
    pdb = 1'b0;
    tick();
    check_out("pd", 17'h0, 6'h0, 1'b0, 1'b0);
    check("pd_rdy", 32'(bus.code_rdy), 32'd0);
    check("pd_dac_on", 32'(dac_on), 32'd0);
    bus.code_vld = 1'b0;
    pdb          = 1'b1;
    wait_run(n_edges, therm_or);
    check("pd_restart_sel", 32'(therm_or), 32'd0);
    send(11'd64);
    check("pd_ptr0", 32'(bus.therm_sel), 32'h00001);

    // Async reset in the middle of a cycle
    send(11'd2047);
    check("pre_rst", 32'(bus.therm_sel), 32'h1FFFF);
    #2;
    rstb = 1'b0;
    #1;
    check("arst_therm", 32'(bus.therm_sel), 32'd0);
    check("arst_sat", 32'(bus.sat_flag), 32'd0);
    check("arst_rdy", 32'(bus.code_rdy), 32'd0);
    tick();
    rstb = 1'b1;
    tick();
    check("rst_off_rdy", 32'(bus.code_rdy), 32'd0);
    wait_run(n_edges, therm_or);
    check("rst_warmup_len", 32'(n_edges), 32'(IDAC_WARMUP_CYC));
    send(11'd677);
    check("rst_ptr0", 32'(bus.therm_sel), 32'h003FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
